// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the program-counter generator: memory handshake,
// redirect sources from core control, and status outputs.
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              fetch_ready;
    logic              br_valid;
    logic [ADDR_W-1:0] br_target;
    logic              exc_valid;
    logic [ADDR_W-1:0] exc_vector;
    logic              halt;
    logic [ADDR_W-1:0] pc;
    logic              req_valid;
    logic              halted;
    logic              misalign_err;

    modport master (
        input  fetch_ready,
        input  br_valid,
        input  br_target,
        input  exc_valid,
        input  exc_vector,
        input  halt,
        output pc,
        output req_valid,
        output halted,
        output misalign_err
    );

    modport slave (
        output fetch_ready,
        output br_valid,
        output br_target,
        output exc_valid,
        output exc_vector,
        output halt,
        input  pc,
        input  req_valid,
        input  halted,
        input  misalign_err
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: issues aligned fetch addresses over valid/ready,
// with prioritised branch/exception redirects (queued while stalled) and halt.
module pc_gen #(
    parameter int                ADDR_W     = 32,
    parameter int                INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic     clk,
    input  logic     reset_n,
    pc_gen_if.master bus
);
    localparam int                ALIGN      = $clog2(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ALIGN) - 1);
    localparam logic [ADDR_W-1:0] INCR       = ADDR_W'(INST_BYTES);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic              v;
        logic              exc;
        logic [ADDR_W-1:0] addr;
    } pend_t;

    state_t            state_q, state_d;
    pend_t             pend_q, pend_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mis_q, mis_d;
    logic              req_valid;
    logic              halted;
    logic              accept;
    logic              load_v;
    logic [ADDR_W-1:0] load_addr;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN:  if (bus.halt && (!req_valid || accept)) state_d = ST_HALT;
            ST_HALT: if (!bus.halt) state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        req_valid = 1'b0;
        halted    = 1'b0;
        case (state_q)
            ST_RUN:  req_valid = 1'b1;
            ST_HALT: halted    = 1'b1;
            default: ;
        endcase
    end

    assign accept = req_valid & bus.fetch_ready;

    // ------------------------------------------------------------------
    // Redirect selection and pending-redirect bookkeeping
    // ------------------------------------------------------------------
    // A stalled request must stay stable, so redirects seen during a stall
    // are parked in pend_q and only applied on the accepting edge.
    always_comb begin
        load_v    = 1'b0;
        load_addr = pc_q;
        pend_d    = pend_q;
        if (req_valid) begin
            if (accept) begin
                pend_d = '0;
                if (bus.exc_valid) begin
                    load_v    = 1'b1;
                    load_addr = bus.exc_vector;
                end else if (pend_q.v && pend_q.exc) begin
                    load_v    = 1'b1;
                    load_addr = pend_q.addr;
                end else if (bus.br_valid) begin
                    load_v    = 1'b1;
                    load_addr = bus.br_target;
                end else if (pend_q.v) begin
                    load_v    = 1'b1;
                    load_addr = pend_q.addr;
                end
            end else if (bus.exc_valid) begin
                pend_d.v    = 1'b1;
                pend_d.exc  = 1'b1;
                pend_d.addr = bus.exc_vector;
            end else if (bus.br_valid && !(pend_q.v && pend_q.exc)) begin
                pend_d.v    = 1'b1;
                pend_d.exc  = 1'b0;
                pend_d.addr = bus.br_target;
            end
        end else if (bus.exc_valid) begin
            load_v    = 1'b1;
            load_addr = bus.exc_vector;
        end else if (bus.br_valid) begin
            load_v    = 1'b1;
            load_addr = bus.br_target;
        end
    end

    // Misalignment is judged on the raw target at the moment it is applied.
    always_comb begin
        pc_d  = pc_q;
        mis_d = 1'b0;
        if (load_v) begin
            pc_d  = load_addr & ~ALIGN_MASK;
            mis_d = |(load_addr & ALIGN_MASK);
        end else if (accept) begin
            pc_d = pc_q + INCR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= RESET_PC;
            pend_q <= '0;
            mis_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
            mis_q  <= mis_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.req_valid    = req_valid;
    assign bus.halted       = halted;
    assign bus.misalign_err = mis_q;
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a 32-bit instance driven from a vector table
// and an 8-bit instance for address wrap, plus a mid-operation reset sequence.
module tb_pc_gen;
    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    pc_gen_if #(.ADDR_W(32)) bus ();
    pc_gen_if #(.ADDR_W(8))  bus8 ();

    pc_gen #(.ADDR_W(32), .INST_BYTES(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    pc_gen #(.ADDR_W(8), .INST_BYTES(4), .RESET_PC(8'h0)) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8)
    );

    always #5 clk = ~clk;

    // f = {fetch_ready, br_valid, exc_valid, halt}; eo = {req_valid, halted, misalign_err}
    typedef struct packed {
        logic [3:0]  f;
        logic [31:0] bt;
        logic [31:0] ev;
        logic [31:0] e_pc;
        logic [2:0]  eo;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t exp_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] f, input logic [31:0] bt, input logic [31:0] ev,
                                input logic [31:0] e_pc, input logic [2:0] eo);
        vec_t v;
        v.f = f; v.bt = bt; v.ev = ev; v.e_pc = e_pc; v.eo = eo;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expected post-edge outputs, then
    // compare them on the following falling edge.
    task automatic run_vec(input vec_t v, input bit on8, input string tag);
        vec_t e;
        if (on8) begin
            {bus8.fetch_ready, bus8.br_valid, bus8.exc_valid, bus8.halt} = v.f;
            bus8.br_target  = v.bt[7:0];
            bus8.exc_vector = v.ev[7:0];
        end else begin
            {bus.fetch_ready, bus.br_valid, bus.exc_valid, bus.halt} = v.f;
            bus.br_target  = v.bt;
            bus.exc_vector = v.ev;
        end
        exp_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        if (on8) begin
            check({tag, ".pc"}, {24'h0, bus8.pc}, e.e_pc);
            check({tag, ".status"}, {29'h0, bus8.req_valid, bus8.halted, bus8.misalign_err},
                  {29'h0, e.eo});
        end else begin
            check({tag, ".pc"}, bus.pc, e.e_pc);
            check({tag, ".status"}, {29'h0, bus.req_valid, bus.halted, bus.misalign_err},
                  {29'h0, e.eo});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        {bus.fetch_ready, bus.br_valid, bus.exc_valid, bus.halt}     = 4'b0000;
        {bus8.fetch_ready, bus8.br_valid, bus8.exc_valid, bus8.halt} = 4'b0000;
        bus.br_target = '0;  bus.exc_vector = '0;
        bus8.br_target = '0; bus8.exc_vector = '0;
        reset_n = 1'b0;

        // Sequential stream from reset
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h0,    3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h4,    3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h8,    3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'hC,    3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h10,   3'b100));
        // Three-cycle stall with a branch in the second stalled cycle
        vecs.push_back(mk(4'b0000, 32'h0,    32'h0,    32'h10,   3'b100));
        vecs.push_back(mk(4'b0100, 32'h100,  32'h0,    32'h10,   3'b100));
        vecs.push_back(mk(4'b0000, 32'h0,    32'h0,    32'h10,   3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h100,  3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h104,  3'b100));
        // Simultaneous exc and br while stalled: exc wins, br dropped
        vecs.push_back(mk(4'b0110, 32'h200,  32'h80,   32'h104,  3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h80,   3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h84,   3'b100));
        // Newer br must not overwrite a pending exc
        vecs.push_back(mk(4'b0010, 32'h0,    32'h300,  32'h84,   3'b100));
        vecs.push_back(mk(4'b0100, 32'h400,  32'h0,    32'h84,   3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h300,  3'b100));
        // Newer br overwrites a pending br
        vecs.push_back(mk(4'b0100, 32'h500,  32'h0,    32'h300,  3'b100));
        vecs.push_back(mk(4'b0100, 32'h600,  32'h0,    32'h300,  3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h600,  3'b100));
        // exc at accept beats a pending exc; pending then gone
        vecs.push_back(mk(4'b0010, 32'h0,    32'h700,  32'h600,  3'b100));
        vecs.push_back(mk(4'b1010, 32'h0,    32'h800,  32'h800,  3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h804,  3'b100));
        // br at accept beats a pending br
        vecs.push_back(mk(4'b0100, 32'h900,  32'h0,    32'h804,  3'b100));
        vecs.push_back(mk(4'b1100, 32'hA00,  32'h0,    32'hA00,  3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'hA04,  3'b100));
        // pending exc beats br at accept
        vecs.push_back(mk(4'b0010, 32'h0,    32'hB00,  32'hA04,  3'b100));
        vecs.push_back(mk(4'b1100, 32'hC00,  32'h0,    32'hB00,  3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'hB04,  3'b100));
        // Misaligned targets, direct and via the pending register
        vecs.push_back(mk(4'b1100, 32'h1002, 32'h0,    32'h1000, 3'b101));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h1004, 3'b100));
        vecs.push_back(mk(4'b0010, 32'h0,    32'h2001, 32'h1004, 3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h2000, 3'b101));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h2004, 3'b100));
        // Halt at 0x20 during a two-cycle stall, then resume
        vecs.push_back(mk(4'b1100, 32'h20,   32'h0,    32'h20,   3'b100));
        vecs.push_back(mk(4'b0001, 32'h0,    32'h0,    32'h20,   3'b100));
        vecs.push_back(mk(4'b0001, 32'h0,    32'h0,    32'h20,   3'b100));
        vecs.push_back(mk(4'b1001, 32'h0,    32'h0,    32'h24,   3'b010));
        vecs.push_back(mk(4'b1001, 32'h0,    32'h0,    32'h24,   3'b010));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h24,   3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h28,   3'b100));
        // Redirect while halted loads pc directly
        vecs.push_back(mk(4'b1001, 32'h0,    32'h0,    32'h2C,   3'b010));
        vecs.push_back(mk(4'b1101, 32'h1237, 32'h0,    32'h1234, 3'b011));
        vecs.push_back(mk(4'b1001, 32'h0,    32'h0,    32'h1234, 3'b010));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h1234, 3'b100));
        vecs.push_back(mk(4'b1000, 32'h0,    32'h0,    32'h1238, 3'b100));

        @(negedge clk);
        check("rst.pc", bus.pc, 32'h0);
        check("rst.status", {29'h0, bus.req_valid, bus.halted, bus.misalign_err}, 32'h0);
        check("rst8.pc", {24'h0, bus8.pc}, 32'h0);
        reset_n = 1'b1;
        #1;
        check("init.req_valid", {31'h0, bus.req_valid}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], 1'b0, $sformatf("v%0d", i));
        end

        // Reset mid-stall with a branch pending: branch must be lost
        run_vec(mk(4'b0100, 32'h5000, 32'h0, 32'h1238, 3'b100), 1'b0, "pend_br");
        bus.br_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst.pc", bus.pc, 32'h0);
        check("async_rst.status", {29'h0, bus.req_valid, bus.halted, bus.misalign_err}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rerelease.req_valid", {31'h0, bus.req_valid}, 32'h0);
        run_vec(mk(4'b1000, 32'h0, 32'h0, 32'h0, 3'b100), 1'b0, "post_rst0");
        run_vec(mk(4'b1000, 32'h0, 32'h0, 32'h4, 3'b100), 1'b0, "post_rst1");
        run_vec(mk(4'b1000, 32'h0, 32'h0, 32'h8, 3'b100), 1'b0, "post_rst2");

        // 8-bit instance: wrap past 0xFC and misaligned branch 0x33
        run_vec(mk(4'b0100, 32'hFC, 32'h0, 32'h0,  3'b100), 1'b1, "w8_0");
        run_vec(mk(4'b1000, 32'h0,  32'h0, 32'hFC, 3'b100), 1'b1, "w8_1");
        run_vec(mk(4'b1000, 32'h0,  32'h0, 32'h00, 3'b100), 1'b1, "w8_2");
        run_vec(mk(4'b1100, 32'h33, 32'h0, 32'h30, 3'b101), 1'b1, "w8_3");
        run_vec(mk(4'b1000, 32'h0,  32'h0, 32'h34, 3'b100), 1'b1, "w8_4");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the instruction-fetch front end, replacing the fixed 32-bit free-running PC. It issues fetch addresses over a valid/ready handshake, advances by a configurable instruction size, and accepts branch and exception redirects with defined priority, including redirects that arrive while a request is stalled. It also supports halt/resume. It sits between the core control logic (redirect and halt sources) and the instruction memory/cache port.

## Interface
- ADDR_W, 32: PC / address width in bits (≥ 8).
- INST_BYTES, 4: sequential increment in bytes; power of two, 1..8. ALIGN = log2(INST_BYTES).
- RESET_PC, 0: PC value loaded at reset; must be INST_BYTES-aligned.

- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- fetch_ready  in  1  memory accepts the current request.
- br_valid  in  1  branch/jump redirect request (single-cycle pulse).
- br_target  in  ADDR_W  branch target.
- exc_valid  in  1  exception redirect request (single-cycle pulse).
- exc_vector  in  ADDR_W  exception handler address.
- halt  in  1  level; stop issuing fetches while high.
- pc  out  ADDR_W  current fetch address.
- req_valid  out  1  pc is a valid fetch request.
- halted  out  1  block is in HALT with no outstanding request.
- misalign_err  out  1  one-cycle pulse: an applied redirect target had nonzero low ALIGN bits.

## Operation
- States:
  - INIT: the one idle cycle after reset release.
  - RUN: issuing fetches.
  - HALT: not issuing.
- Transitions:
  - INIT → RUN unconditionally.
  - RUN → HALT when halt=1 and either req_valid=0 or the current request is accepted.
  - HALT → RUN when halt=0.
- req_valid=1 only in RUN.
- accept = req_valid & fetch_ready.
- While req_valid=1 and accept=0, pc and req_valid hold stable. No request is ever withdrawn.
- Pending redirect register (pend_v, pend_exc, pend_addr):
  - Captures a redirect arriving in a cycle without accept.
  - exc overwrites pending br.
  - A newer br overwrites a pending br but never a pending exc.
  - Cleared when applied.
- Next pc on accept, in priority order:
  1. exc_valid → exc_vector.
  2. Pending exc → pend_addr.
  3. br_valid → br_target.
  4. Pending br → pend_addr.
  5. Otherwise pc + INST_BYTES.
- When req_valid=0 (INIT, HALT, or RUN with req_valid low), a redirect is applied to pc directly on the next edge, with the same priority; the pending register is not used.
- Arithmetic: pc + INST_BYTES is modulo 2^ADDR_W. The all-ones-aligned address wraps to 0, with no flag.
- Redirect targets have their low ALIGN bits forced to 0 when loaded. misalign_err pulses in the cycle after that load if any discarded bit was 1.
- exc_valid and br_valid in the same cycle: exc wins, and the br is discarded (not queued).

## Timing
- Reset values: pc=RESET_PC, req_valid=0, halted=0, misalign_err=0, state INIT, pend_v=0.
- Reset is asynchronous mid-operation: all of the above apply immediately, and pending redirects are lost.
- Cycle 0 after reset release (INIT): req_valid=0. Cycle 1: req_valid=1, pc=RESET_PC.
- Sequential throughput with fetch_ready=1: a new pc every cycle, with one cycle of latency from accept to the next pc.
- Redirect latency:
  - Target visible on pc the cycle after the accepting edge, or the cycle after the redirect if req_valid=0.
  - The request in flight at redirect time is still issued. Squashing is the consumer's job.
- halt asserted in RUN: at most one further accept, then req_valid=0 and halted=1 from the next cycle.
- halt deasserted: req_valid=1 the next cycle at the held pc.

## Test plan
- Reset, release, fetch_ready=1, defaults → req_valid rises at cycle 1; pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- fetch_ready=0 for 3 cycles at pc=0x10, with br_valid pulse target 0x100 in the 2nd stalled cycle → pc stays 0x10 throughout the stall; after accept, pc=0x100, then 0x104.
- Same cycle exc_valid (vector 0x80) and br_valid (target 0x200) while stalled → after accept pc=0x80; 0x200 never appears.
- ADDR_W=8, INST_BYTES=4, pc=0xFC accepted → next pc=0x00. br_target=0x33 → pc=0x30 and misalign_err pulses exactly one cycle.
- halt=1 at pc=0x20 with fetch_ready=0 for 2 cycles → pc 0x20 accepted, then req_valid=0 and halted=1. halt=0 → req_valid=1 with pc=0x24.
- Assert reset_n low while a br is pending and stalled → pc=RESET_PC and req_valid=0 immediately. After release, the first fetch is RESET_PC and the branch is never applied.
